// File: rtl/hubris_boot_mem.sv
// rtl/hubris_boot_mem.sv - dual-port boot memory for the Hubris core with byte-stream loader
module hubris_boot_mem #(
  parameter int unsigned DEPTH_WORDS        = 4096,
  parameter int          WORD_WIDTH_IN_BYTE = 4,
  parameter bit          SKIP_LOAD          = 1'b0,
  parameter string       INIT_FILE          = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_a,
  input  logic [3:0]  we_a,
  input  logic [31:0] addr_a,
  input  logic [31:0] din_a,
  output logic [31:0] dout_a,
  input  logic        en_b,
  input  logic [3:0]  we_b,
  input  logic [31:0] addr_b,
  input  logic [31:0] din_b,
  output logic [31:0] dout_b,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  input  logic        reload,
  output logic        core_reset,
  output logic [31:0] loaded_words
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_LOAD_LEN  = 2'd0,
    ST_LOAD_DATA = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  state_t         state;
  logic [1:0]     byte_cnt;
  logic [23:0]    shreg;
  logic [31:0]    len_n;

  logic [31:0]    mem [DEPTH_WORDS];

  logic [AW-1:0]  idx_a;
  logic [AW-1:0]  idx_b;
  logic           load_fire;
  logic [31:0]    load_word;

  logic [3:0]     wr_lanes;
  logic [AW-1:0]  wr_idx;
  logic [31:0]    wr_data;

  // Address bits that do not select a word (byte offset, aliased upper bits) and the
  // write-side inputs of the read-only port are deliberately discarded.
  logic           unused_bits;
  assign unused_bits = ^{we_b, din_b, addr_a[30:AW+2], addr_a[1:0],
                         addr_b[30:AW+2], addr_b[1:0]};

  assign idx_a     = addr_a[AW+1:2];
  assign idx_b     = addr_b[AW+1:2];
  assign load_fire = load_valid && load_ready;
  // Little-endian: the byte arriving now is the most significant of the word.
  assign load_word = {load_data, shreg};

  // Single write port shared by the loader (LOAD_DATA) and core port A (RUN).
  always_comb begin
    wr_lanes = 4'b0000;
    wr_idx   = idx_a;
    wr_data  = din_a;
    if (reset) begin
      if (state == ST_LOAD_DATA) begin
        if (load_fire && byte_cnt == 2'd3 && loaded_words < 32'(DEPTH_WORDS)) begin
          wr_lanes = 4'b1111;
          wr_idx   = loaded_words[AW-1:0];
          wr_data  = load_word;
        end
      end else if (state == ST_RUN && en_a && !addr_a[31]) begin
        wr_lanes = we_a;
      end
    end
  end

  // Byte-lane memory write; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_WIDTH_IN_BYTE; i++) begin
      if (wr_lanes[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Registered read-first ports; zero while loading, hold when not enabled.
  always_ff @(posedge clk) begin
    if (!reset || state != ST_RUN) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      if (en_a) begin
        dout_a <= addr_a[31] ? 32'd0 : mem[idx_a];
      end
      if (en_b) begin
        dout_b <= addr_b[31] ? 32'd0 : mem[idx_b];
      end
    end
  end

  // Boot-loader FSM: length word, N data words, then release the core.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (SKIP_LOAD) begin
        state <= ST_RUN;
      end else begin
        state <= ST_LOAD_LEN;
      end
      load_ready   <= 1'b0;
      core_reset   <= ~SKIP_LOAD;
      loaded_words <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      len_n        <= '0;
    end else begin
      case (state)
        ST_LOAD_LEN: begin
          load_ready <= 1'b1;
          core_reset <= 1'b1;
          if (load_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {load_data, shreg[23:8]};
            if (byte_cnt == 2'd3) begin
              len_n <= load_word;
              if (load_word == 32'd0) begin
                state      <= ST_RUN;
                load_ready <= 1'b0;
                core_reset <= 1'b0;
              end else begin
                state <= ST_LOAD_DATA;
              end
            end
          end
        end
        ST_LOAD_DATA: begin
          load_ready <= 1'b1;
          core_reset <= 1'b1;
          if (load_fire) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {load_data, shreg[23:8]};
            if (byte_cnt == 2'd3) begin
              loaded_words <= loaded_words + 32'd1;
              if (loaded_words + 32'd1 == len_n) begin
                state      <= ST_RUN;
                load_ready <= 1'b0;
                core_reset <= 1'b0;
              end
            end
          end
        end
        ST_RUN: begin
          load_ready <= 1'b0;
          core_reset <= 1'b0;
          byte_cnt   <= '0;
          if (reload) begin
            state        <= ST_LOAD_LEN;
            loaded_words <= '0;
            load_ready   <= 1'b1;
            core_reset   <= 1'b1;
          end
        end
        default: begin
          state      <= ST_LOAD_LEN;
          load_ready <= 1'b0;
          core_reset <= 1'b1;
          byte_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hubris_boot_mem.sv
// tb/tb_hubris_boot_mem.sv - directed self-checking bench for hubris_boot_mem
module tb_hubris_boot_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_a;
  logic [3:0]  we_a;
  logic [31:0] addr_a;
  logic [31:0] din_a;
  logic [31:0] dout_a;
  logic        en_b;
  logic [3:0]  we_b;
  logic [31:0] addr_b;
  logic [31:0] din_b;
  logic [31:0] dout_b;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        reload;
  logic        core_reset;
  logic [31:0] loaded_words;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hubris_boot_mem dut (
    .clk          (clk),
    .reset        (reset),
    .en_a         (en_a),
    .we_a         (we_a),
    .addr_a       (addr_a),
    .din_a        (din_a),
    .dout_a       (dout_a),
    .en_b         (en_b),
    .we_b         (we_b),
    .addr_b       (addr_b),
    .din_b        (din_b),
    .dout_b       (dout_b),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .reload       (reload),
    .core_reset   (core_reset),
    .loaded_words (loaded_words)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic hs;
    int   k;
    load_valid = 1'b1;
    load_data  = b;
    hs = 1'b0;
    k  = 0;
    while (!hs && k < 20) begin
      hs = load_ready;
      step();
      k++;
    end
    if (!hs) check("load_hs_timeout", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic acc_a(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] din);
    en_a = 1'b1; we_a = we; addr_a = addr; din_a = din;
    step();
    en_a = 1'b0; we_a = 4'h0;
  endtask

  task automatic read_b(input logic [31:0] addr);
    en_b = 1'b1; addr_b = addr;
    step();
    en_b = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en_a = 1'b0; we_a = 4'h0; addr_a = '0; din_a = '0;
    en_b = 1'b0; we_b = 4'hF; addr_b = '0; din_b = 32'hFFFF_FFFF;
    load_valid = 1'b0; load_data = '0; reload = 1'b0;

    // 1: reset state
    repeat (3) step();
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_load_ready", {31'd0, load_ready}, 32'd0);
    check("rst_dout_a", dout_a, 32'd0);
    check("rst_dout_b", dout_b, 32'd0);
    check("rst_loaded_words", loaded_words, 32'd0);
    reset = 1'b1;
    step();
    check("rel_load_ready", {31'd0, load_ready}, 32'd1);

    // 2: one-word program
    send_word(32'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00);
    check("pre_last_core_reset", {31'd0, core_reset}, 32'd1);
    send_byte(8'h00);
    check("ld1_loaded_words", loaded_words, 32'd1);
    check("ld1_core_reset", {31'd0, core_reset}, 32'd0);
    check("ld1_load_ready", {31'd0, load_ready}, 32'd0);
    read_b(32'h0);
    check("fetch0", dout_b, 32'h0000_0013);
    addr_b = 32'h10;
    step();
    check("b_hold", dout_b, 32'h0000_0013);
    load_valid = 1'b1; load_data = 8'hFF;
    step(); step();
    load_valid = 1'b0;
    check("run_byte_ignored", loaded_words, 32'd1);
    check("run_load_ready", {31'd0, load_ready}, 32'd0);

    // 3: byte lanes and read-first
    acc_a(4'hF, 32'h10, 32'hAABB_CCDD);
    acc_a(4'b0010, 32'h10, 32'h0000_1100);
    acc_a(4'h0, 32'h10, 32'h0);
    check("lane_merge", dout_a, 32'hAABB_11DD);
    en_b = 1'b1; addr_b = 32'h10;
    acc_a(4'hF, 32'h10, 32'h1234_5678);
    en_b = 1'b0;
    check("a_read_first", dout_a, 32'hAABB_11DD);
    check("b_read_old", dout_b, 32'hAABB_11DD);
    acc_a(4'h0, 32'h10, 32'h0);
    check("a_new_value", dout_a, 32'h1234_5678);

    // 4: MMIO space and aliasing
    acc_a(4'hF, 32'h4, 32'h1111_2222);
    acc_a(4'hF, 32'h8000_0004, 32'hDEAD_BEEF);
    acc_a(4'h0, 32'h4, 32'h0);
    check("mmio_no_write", dout_a, 32'h1111_2222);
    acc_a(4'h0, 32'h8000_0000, 32'h0);
    check("mmio_read_zero", dout_a, 32'h0);
    acc_a(4'h0, 32'h0001_0012, 32'h0);
    check("alias_read", dout_a, 32'h1234_5678);

    // 5: N = DEPTH_WORDS + 1
    reload = 1'b1; step(); reload = 1'b0;
    check("reload_core_reset", {31'd0, core_reset}, 32'd1);
    check("reload_loaded_words", loaded_words, 32'd0);
    send_word(32'd4097);
    for (int w = 0; w < 4096; w++) send_word(32'h5A00_0000 | w);
    check("full_loaded_words", loaded_words, 32'd4096);
    check("full_core_reset", {31'd0, core_reset}, 32'd1);
    send_word(32'hCAFE_F00D);
    check("over_loaded_words", loaded_words, 32'd4097);
    check("over_core_reset", {31'd0, core_reset}, 32'd0);
    acc_a(4'h0, 32'h0, 32'h0);
    check("over_mem0_intact", dout_a, 32'h5A00_0000);
    read_b(32'h3FFC);
    check("last_word", dout_b, 32'h5A00_0FFF);

    // 6: reset mid-load, then reload
    reload = 1'b1; step(); reload = 1'b0;
    acc_a(4'hF, 32'h8, 32'hFFFF_FFFF);
    check("load_port_a_zero", dout_a, 32'h0);
    send_word(32'd2);
    send_byte(8'h77); send_byte(8'h66);
    reset = 1'b0;
    step();
    check("mid_rst_load_ready", {31'd0, load_ready}, 32'd0);
    reset = 1'b1;
    step();
    check("mid_rel_load_ready", {31'd0, load_ready}, 32'd1);
    check("mid_rel_loaded_words", loaded_words, 32'd0);
    send_word(32'd1);
    send_word(32'h0000_0099);
    check("reld_loaded_words", loaded_words, 32'd1);
    check("reld_core_reset", {31'd0, core_reset}, 32'd0);
    acc_a(4'h0, 32'h0, 32'h0);
    check("reld_mem0", dout_a, 32'h0000_0099);
    acc_a(4'h0, 32'h4, 32'h0);
    check("prior_mem1_kept", dout_a, 32'h5A00_0001);
    acc_a(4'h0, 32'h8, 32'h0);
    check("load_write_ignored", dout_a, 32'h5A00_0002);
    reload = 1'b1; step(); reload = 1'b0;
    check("final_core_reset", {31'd0, core_reset}, 32'd1);
    check("final_loaded_words", loaded_words, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
